// File: rtl/lsu_memory_stage.sv
// lsu_memory_stage: memory-stage load/store unit driving a req/gnt/rvalid data bus,
// stalling the pipeline while an access is outstanding and formatting load data.
module lsu_memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_memory,
    input  logic                  memRead_memory,
    input  logic                  memWrite_memory,
    input  logic [2:0]            funct3_memory,
    input  logic [ADDR_WIDTH-1:0] address_memory,
    input  logic [DATA_WIDTH-1:0] store_data_memory,
    output logic [DATA_WIDTH-1:0] memory_data_memory,
    output logic                  stall_memory,
    output logic                  misaligned_fault,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_next;
    logic                  op, illegal, misaligned, fault, issue, idle, we_hold, load_hold;
    logic [2:0]            funct3_hold;
    logic [1:0]            lane, lane_hold;
    logic [3:0]            be_new, be_hold;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [ADDR_WIDTH-1:0] addr_new, addr_hold;
    logic [DATA_WIDTH-1:0] wdata_new, wdata_hold, load_value;

    assign idle       = state == IDLE;
    assign lane       = address_memory[1:0];
    assign op         = valid_memory && (memRead_memory || memWrite_memory);
    assign illegal    = funct3_memory == 3'b011 || funct3_memory[2:1] == 2'b11;
    assign misaligned = (funct3_memory[1:0] == 2'b01 && lane[0]) || (funct3_memory[1:0] == 2'b10 && lane != 2'b00);
    assign fault      = illegal || misaligned;
    assign issue      = idle && op && !fault;

    assign addr_new  = {address_memory[ADDR_WIDTH-1:2], 2'b00};
    assign be_new    = memRead_memory ? 4'b1111
                     : funct3_memory[1:0] == 2'b00 ? 4'b0001 << lane
                     : funct3_memory[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011)
                     : 4'b1111;
    assign wdata_new = funct3_memory[1:0] == 2'b00 ? {4{store_data_memory[7:0]}}
                     : funct3_memory[1:0] == 2'b01 ? {2{store_data_memory[15:0]}}
                     : store_data_memory;

    // In IDLE the bus mirrors the incoming op so a same-cycle grant sees valid fields
    assign dmem_req         = issue || state == REQ;
    assign dmem_we          = issue ? memWrite_memory : !idle && we_hold;
    assign dmem_addr        = issue ? addr_new : idle ? '0 : addr_hold;
    assign dmem_be          = issue ? be_new : idle ? 4'b0000 : be_hold;
    assign dmem_wdata       = issue ? wdata_new : idle ? '0 : wdata_hold;
    assign stall_memory     = issue || state == REQ || state == WAIT;
    assign misaligned_fault = idle && op && fault;

    assign byte_sel   = dmem_rdata[{lane_hold, 3'b000} +: 8];
    assign half_sel   = lane_hold[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign load_value = funct3_hold[1:0] == 2'b00 ? {{24{!funct3_hold[2] && byte_sel[7]}}, byte_sel}
                      : funct3_hold[1:0] == 2'b01 ? {{16{!funct3_hold[2] && half_sel[15]}}, half_sel}
                      : dmem_rdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = issue ? (dmem_gnt ? WAIT : REQ) : IDLE;
            REQ:     state_next = dmem_gnt ? WAIT : REQ;
            WAIT:    state_next = dmem_rvalid ? DONE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            we_hold            <= 1'b0;
            load_hold          <= 1'b0;
            funct3_hold        <= 3'b000;
            lane_hold          <= 2'b00;
            be_hold            <= 4'b0000;
            addr_hold          <= '0;
            wdata_hold         <= '0;
            memory_data_memory <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                we_hold     <= memWrite_memory;
                load_hold   <= memRead_memory;
                funct3_hold <= funct3_memory;
                lane_hold   <= lane;
                be_hold     <= be_new;
                addr_hold   <= addr_new;
                wdata_hold  <= wdata_new;
            end
            if (state == WAIT && dmem_rvalid && load_hold)
                memory_data_memory <= load_value;
        end
    end
endmodule

// File: tb/tb_lsu_memory_stage.sv
// tb_lsu_memory_stage: table-driven bench for lsu_memory_stage with a load-result scoreboard
module tb_lsu_memory_stage;
    logic        clock = 0, reset = 1;
    logic        valid_memory = 0, memRead_memory = 0, memWrite_memory = 0;
    logic [2:0]  funct3_memory = 0;
    logic [31:0] address_memory = 0, store_data_memory = 0, dmem_rdata = 0;
    logic        dmem_gnt = 0, dmem_rvalid = 0;
    logic [31:0] memory_data_memory, dmem_addr, dmem_wdata;
    logic        stall_memory, misaligned_fault, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    int          tests = 0, failed = 0;
    logic [31:0] model_mdm = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          gw, rw;
        bit          fault;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata, edata;
    } vec_t;
    vec_t vecs[$];

    lsu_memory_stage dut (
        .clock(clock), .reset(reset), .valid_memory(valid_memory),
        .memRead_memory(memRead_memory), .memWrite_memory(memWrite_memory),
        .funct3_memory(funct3_memory), .address_memory(address_memory),
        .store_data_memory(store_data_memory), .memory_data_memory(memory_data_memory),
        .stall_memory(stall_memory), .misaligned_fault(misaligned_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int gw, input int rw,
                                input bit fault, input logic [31:0] eaddr, input logic [3:0] ebe,
                                input logic [31:0] ewdata, input logic [31:0] edata);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.gw = gw; v.rw = rw; v.fault = fault; v.eaddr = eaddr; v.ebe = ebe;
        v.ewdata = ewdata; v.edata = edata;
        return v;
    endfunction

    task automatic do_op(input vec_t v);
        int  rv_cyc, stalls;
        bit  done;
        rv_cyc = v.gw + 1 + v.rw;
        stalls = 0;
        done   = 0;
        @(negedge clock);
        valid_memory = 1; memRead_memory = v.ld; memWrite_memory = v.st;
        funct3_memory = v.f3; address_memory = v.addr; store_data_memory = v.sdata;
        dmem_rdata = v.rdata; dmem_rvalid = 0;
        if (v.fault) begin
            dmem_gnt = 1;
            #1;
            chk("fault_flag", 32'(misaligned_fault), 1);
            chk("fault_req", 32'(dmem_req), 0);
            chk("fault_stall", 32'(stall_memory), 0);
            @(negedge clock);
            valid_memory = 0; dmem_gnt = 0;
            #1;
            chk("fault_clear", 32'(misaligned_fault), 0);
            chk("fault_noreq", 32'(dmem_req), 0);
            chk("fault_nostall", 32'(stall_memory), 0);
            return;
        end
        sb_q.push_back(v.ld ? v.edata : model_mdm);
        if (v.ld) model_mdm = v.edata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clock);
            dmem_gnt = (c == v.gw);
            dmem_rvalid = (c == rv_cyc);
            #1;
            if (c == 0) chk("no_fault", 32'(misaligned_fault), 0);
            if (!stall_memory) begin
                done = 1;
                chk("done_cycle", c, rv_cyc + 1);
                chk("stall_cycles", stalls, rv_cyc + 1);
                chk("done_req", 32'(dmem_req), 0);
                if (sb_q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL scoreboard: got empty queue, expected an entry");
                end else chk("load_data", memory_data_memory, sb_q.pop_front());
            end else begin
                stalls++;
                chk("req", 32'(dmem_req), 32'(c <= v.gw));
                if (c <= v.gw) begin
                    chk("addr", dmem_addr, v.eaddr);
                    chk("be", 32'(dmem_be), 32'(v.ebe));
                    chk("we", 32'(dmem_we), 32'(v.st));
                    if (v.st) chk("wdata", dmem_wdata, v.ewdata);
                end
            end
        end
        if (!done) begin
            tests++; failed++;
            $display("FAIL timeout: got no DONE, expected DONE by cycle %0d", rv_cyc + 1);
        end
    endtask

    initial begin
        // ld st f3 addr sdata rdata gw rw fault eaddr be wdata edata
        vecs.push_back(mk(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 32'h100, 4'hF, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'hF, 0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'hF, 0, 32'h00000080));
        vecs.push_back(mk(1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 0, 0, 0, 32'h100, 4'hF, 0, 32'hFFFF8001));
        vecs.push_back(mk(1, 0, 3'b101, 32'h102, 0, 32'h80017FFF, 0, 0, 0, 32'h100, 4'hF, 0, 32'h00008001));
        vecs.push_back(mk(1, 0, 3'b001, 32'h100, 0, 32'h80017FFF, 0, 0, 0, 32'h100, 4'hF, 0, 32'h00007FFF));
        vecs.push_back(mk(1, 0, 3'b000, 32'h101, 0, 32'h12345678, 1, 0, 0, 32'h100, 4'hF, 0, 32'h00000056));
        vecs.push_back(mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 1, 0, 32'h200, 4'hC, 32'hABCDABCD, 0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h301, 32'h112233A5, 0, 0, 0, 0, 32'h300, 4'h2, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 0, 0, 0, 0, 32'h404, 4'hF, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h500, 0, 32'h0BADF00D, 3, 1, 0, 32'h500, 4'hF, 0, 32'h0BADF00D));
        vecs.push_back(mk(0, 1, 3'b000, 32'h003, 32'h0000007F, 0, 1, 2, 0, 32'h000, 4'h8, 32'h7F7F7F7F, 0));
        vecs.push_back(mk(1, 0, 3'b100, 32'h002, 0, 32'hA1B2C3D4, 2, 0, 0, 32'h000, 4'hF, 0, 32'h000000B2));
        vecs.push_back(mk(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h201, 32'h5555AAAA, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b110, 32'h000, 32'h5555AAAA, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b001, 32'h103, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        repeat (2) @(negedge clock);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_stall", 32'(stall_memory), 0);
        chk("rst_fault", 32'(misaligned_fault), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_data", memory_data_memory, 0);
        reset = 0;

        foreach (vecs[i]) do_op(vecs[i]);

        // Stray gnt/rvalid with no op in flight must be ignored
        @(negedge clock);
        valid_memory = 0; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("stray_req", 32'(dmem_req), 0);
        chk("stray_stall", 32'(stall_memory), 0);
        @(negedge clock);
        dmem_gnt = 0; dmem_rvalid = 0;
        #1;
        chk("stray_data", memory_data_memory, model_mdm);
        chk("stray_req2", 32'(dmem_req), 0);

        // Reset while waiting for the response
        @(negedge clock);
        valid_memory = 1; memRead_memory = 1; memWrite_memory = 0; funct3_memory = 3'b010;
        address_memory = 32'h600; dmem_gnt = 1;
        #1;
        chk("rw_req", 32'(dmem_req), 1);
        @(negedge clock);
        dmem_gnt = 0;
        #1;
        chk("rw_wait_stall", 32'(stall_memory), 1);
        chk("rw_wait_req", 32'(dmem_req), 0);
        @(negedge clock);
        reset = 1; valid_memory = 0;
        @(negedge clock);
        #1;
        chk("rw_req0", 32'(dmem_req), 0);
        chk("rw_stall0", 32'(stall_memory), 0);
        chk("rw_we0", 32'(dmem_we), 0);
        chk("rw_addr0", dmem_addr, 0);
        chk("rw_be0", 32'(dmem_be), 0);
        chk("rw_data0", memory_data_memory, 0);
        reset = 0;
        model_mdm = 0;
        do_op(mk(1, 0, 3'b010, 32'h700, 0, 32'h13579BDF, 0, 0, 0, 32'h700, 4'hF, 0, 32'h13579BDF));

        @(negedge clock);
        valid_memory = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
